// File: rtl/dff_equiv_check_ctrl.sv
// Self-check sequencer for the three D flip-flop implementations (SR, JK, T).
// It resets the datapath, checks that all three outputs clear, then drives
// an LFSR-generated D stream and compares every Q output against the
// driven D bit. Results: pass flag, saturating error count, sticky
// per-implementation failure mask and the index of the first failing vector.
//
// Handshake: 'start' is a level sampled only in IDLE. 'busy' covers the
// whole run. 'done' pulses for one cycle when the run ends. 'pass',
// 'err_count', 'fail_mask' and 'first_fail' are valid from 'done' and are
// held until the next accepted 'start'.
//
// All outputs are registered. Each output register loads the value that
// belongs to the state being entered, so registered outputs line up with
// the state register.
module dff_equiv_check_ctrl #(
    parameter int          NUM_VECTORS = 16,
    parameter int          SETTLE      = 1,
    parameter int          RST_CYCLES  = 2,
    parameter logic [7:0]  SEED        = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       dut_rst,
    output logic       dut_d,
    input  logic       q_sr,
    input  logic       q_jk,
    input  logic       q_t,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_count,
    output logic [2:0] fail_mask,
    output logic [7:0] first_fail,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RST    = 3'd1,
        S_CHKRST = 3'd2,
        S_DRIVE  = 3'd3,
        S_SAMPLE = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [7:0] FF_NONE  = 8'hFF;
    localparam logic [7:0] FF_RESET = 8'hFE;
    localparam logic [7:0] LAST_IDX = 8'(NUM_VECTORS - 1);
    localparam logic [3:0] RST_LAST = 4'(RST_CYCLES - 1);
    localparam logic [3:0] SET_LAST = 4'(SETTLE);

    state_t     state_q;
    state_t     next_state;
    logic [3:0] wait_q;
    logic [7:0] lfsr_q;
    logic [7:0] idx_q;

    logic [7:0] lfsr_nx;
    logic [7:0] idx_nx;
    logic [7:0] err_nx;
    logic [2:0] mask_nx;
    logic [7:0] first_nx;
    logic       pass_nx;
    logic       dut_rst_nx;
    logic       dut_d_nx;
    logic       busy_nx;
    logic       done_nx;
    logic [2:0] miss;
    logic [7:0] err_inc;

    assign dbg_state = state_q;

    // State register plus a dwell counter that restarts on every state change.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            wait_q  <= 4'd0;
        end else begin
            state_q <= next_state;
            wait_q  <= (next_state != state_q) ? 4'd0 : wait_q + 4'd1;
        end
    end

    // Next-state logic: reset hold, reset check, drive/sample per vector.
    always_comb begin
        next_state = state_q;
        case (state_q)
            S_IDLE:   if (start) next_state = S_RST;
            S_RST:    if (wait_q == RST_LAST) next_state = S_CHKRST;
            S_CHKRST: next_state = S_DRIVE;
            S_DRIVE:  if (wait_q == SET_LAST) next_state = S_SAMPLE;
            S_SAMPLE: next_state = (idx_q == LAST_IDX) ? S_DONE : S_DRIVE;
            S_DONE:   next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    // Next values of the result registers and of all registered outputs.
    always_comb begin
        lfsr_nx  = lfsr_q;
        idx_nx   = idx_q;
        err_nx   = err_count;
        mask_nx  = fail_mask;
        first_nx = first_fail;
        pass_nx  = pass;
        miss     = 3'b000;
        err_inc  = (err_count == 8'hFF) ? err_count : err_count + 8'd1;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    lfsr_nx  = SEED;
                    idx_nx   = 8'd0;
                    err_nx   = 8'd0;
                    mask_nx  = 3'b000;
                    first_nx = FF_NONE;
                    pass_nx  = 1'b0;
                end
            end
            S_CHKRST: begin
                miss = {q_t, q_jk, q_sr};
                if (|miss) begin
                    mask_nx  = fail_mask | miss;
                    err_nx   = err_inc;
                    first_nx = FF_RESET;
                end
            end
            S_SAMPLE: begin
                miss = {q_t, q_jk, q_sr} ^ {3{dut_d}};
                if (|miss) begin
                    mask_nx = fail_mask | miss;
                    err_nx  = err_inc;
                    if (first_fail == FF_NONE) first_nx = idx_q;
                end
                lfsr_nx = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
                idx_nx  = idx_q + 8'd1;
            end
            default: ;
        endcase

        if (next_state == S_DONE) pass_nx = (err_nx == 8'd0) && (mask_nx == 3'b000);

        dut_rst_nx = (next_state == S_IDLE) || (next_state == S_RST) || (next_state == S_DONE);
        dut_d_nx   = ((next_state == S_DRIVE) || (next_state == S_SAMPLE)) ? lfsr_nx[0] : 1'b0;
        busy_nx    = (next_state != S_IDLE) && (next_state != S_DONE);
        done_nx    = (next_state == S_DONE);
    end

    // Output and result registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            lfsr_q     <= SEED;
            idx_q      <= 8'd0;
            err_count  <= 8'd0;
            fail_mask  <= 3'b000;
            first_fail <= FF_NONE;
            pass       <= 1'b0;
            dut_rst    <= 1'b1;
            dut_d      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            lfsr_q     <= lfsr_nx;
            idx_q      <= idx_nx;
            err_count  <= err_nx;
            fail_mask  <= mask_nx;
            first_fail <= first_nx;
            pass       <= pass_nx;
            dut_rst    <= dut_rst_nx;
            dut_d      <= dut_d_nx;
            busy       <= busy_nx;
            done       <= done_nx;
        end
    end

endmodule
